// File: rtl/coherence_bus_arbiter.sv
// Two-cache snooping bus arbiter: round-robin grant, one-cycle snoop, dirty
// cache-to-cache supply with RAM update, and block lock while cctrans is held.
module coherence_bus_arbiter (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       cctrans,
    input  logic [1:0]       dREN,
    input  logic [1:0]       dWEN,
    input  logic [1:0][31:0] daddr,
    input  logic [1:0][31:0] dstore,
    input  logic [1:0]       ccwrite,
    input  logic [1:0]       ccdirty,
    output logic [1:0]       dwait,
    output logic [1:0][31:0] dload,
    output logic [1:0]       ccwait,
    output logic [1:0]       ccinv,
    output logic [1:0][31:0] ccsnoopaddr,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic             ramready
);

    typedef enum logic [2:0] {IDLE, SNOOP, SUPPLY, MEM, DONE} state_t;

    state_t state_q;
    logic   owner_q;
    logic   last_grant_q;

    logic [1:0] valid;
    logic       grant;
    logic       peer;

    assign valid = cctrans & (dREN | dWEN);
    assign peer  = ~owner_q;

    // A tie goes to the cache that was not served last.
    always_comb begin
        grant = valid[1];
        if (valid == 2'b11) begin
            grant = ~last_grant_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|valid) begin
                        owner_q <= grant;
                        state_q <= dWEN[grant] ? MEM : SNOOP;
                    end
                end
                SNOOP: begin
                    state_q <= ccdirty[peer] ? SUPPLY : MEM;
                end
                SUPPLY, MEM: begin
                    if (ramready) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Lock held: next word skips arbitration; no strobe means wait here.
                    if (cctrans[owner_q]) begin
                        if (dWEN[owner_q]) begin
                            state_q <= MEM;
                        end else if (dREN[owner_q]) begin
                            state_q <= SNOOP;
                        end
                    end else begin
                        last_grant_q <= owner_q;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        if (!RST) begin
            case (state_q)
                SNOOP: begin
                    ccwait[peer]      = 1'b1;
                    ccinv[peer]       = ccwrite[owner_q];
                    ccsnoopaddr[peer] = daddr[owner_q];
                end
                SUPPLY: begin
                    // Snooped cache keeps the address so it can drive its dirty word.
                    ccwait[peer]      = 1'b1;
                    ccinv[peer]       = ccwrite[owner_q];
                    ccsnoopaddr[peer] = daddr[owner_q];
                    ramWEN            = 1'b1;
                    ramaddr           = daddr[owner_q];
                    ramstore          = dstore[peer];
                    dload[owner_q]    = dstore[peer];
                    dwait[owner_q]    = ~ramready;
                end
                MEM: begin
                    ramREN         = dREN[owner_q] & ~dWEN[owner_q];
                    ramWEN         = dWEN[owner_q];
                    ramaddr        = daddr[owner_q];
                    ramstore       = dstore[owner_q];
                    dload[owner_q] = ramload;
                    dwait[owner_q] = ~ramready;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/coherence_bus_arbiter.md
COHERENCE_BUS_ARBITER -- requirements
Module: coherence_bus_arbiter

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: RST  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: cctrans  in  2  per-cache bus request; bit i = cache i; held high across a whole block.
REQ-004 SHALL have: dREN, dWEN  in  2 each  per-cache word read / word write strobe.
REQ-005 SHALL have: daddr, dstore  in  2x32 each  per-cache word address / write data.
REQ-006 SHALL have: ccwrite  in  2  requester intends to modify, so the snoop must invalidate.
REQ-007 SHALL have: ccdirty  in  2  snooped cache holds the snoop address dirty, and drives that word on its dstore.
REQ-008 SHALL have: dwait  out  2  high = word not complete for cache i.
REQ-009 SHALL have: dload  out  2x32  read data to cache i.
REQ-010 SHALL have: ccwait, ccinv  out  2 each  freeze cache i for snoop / invalidate snooped line.
REQ-011 SHALL have: ccsnoopaddr  out  2x32  snoop address to cache i.
REQ-012 SHALL have: ramREN, ramWEN  out  1 each; ramaddr, ramstore  out  32 each; ramload  in  32; ramready  in  1 (RAM word done).

Function
REQ-013 SHALL implement states IDLE, SNOOP, SUPPLY, MEM, DONE; registers: owner (1b), last_grant (1b).
REQ-014 IDLE: a valid request is cctrans[i] && (dREN[i] || dWEN[i]); cctrans with neither strobe is ignored.
REQ-015 IDLE, one valid requester: owner <= i; both valid: owner <= !last_grant (round robin).
REQ-016 IDLE exit: owner dWEN -> MEM (writebacks not snooped); owner dREN only -> SNOOP; dWEN wins if both strobes are high.
REQ-017 SNOOP, exactly 1 cycle, o = !owner: ccwait[o]=1, ccsnoopaddr[o]=daddr[owner], ccinv[o]=ccwrite[owner].
REQ-018 SNOOP: ccdirty[o] sampled at the end of the cycle -> SUPPLY if 1, else MEM.
REQ-019 SUPPLY: ccwait[o]=1, ccinv[o]=ccwrite[owner]; ramWEN=1, ramaddr=daddr[owner], ramstore=dstore[o]; dload[owner]=dstore[o].
REQ-020 SUPPLY: dwait[owner]=!ramready; ramready -> DONE. The cache-to-cache transfer also updates RAM.
REQ-021 MEM: ramREN=dREN[owner]&&!dWEN[owner], ramWEN=dWEN[owner], ramaddr=daddr[owner], ramstore=dstore[owner].
REQ-022 MEM: dload[owner]=ramload, dwait[owner]=!ramready; ramready -> DONE.
REQ-023 DONE, 1 cycle: all dwait=1, no RAM strobes.
REQ-024 DONE, cctrans[owner] still high: lock kept; owner's next word goes to SNOOP/MEM per REQ-016, without re-arbitration.
REQ-025 DONE, lock kept but owner has no strobe: SHALL stay in DONE.
REQ-026 DONE, cctrans[owner] low: last_grant <= owner, -> IDLE.
REQ-027 A word in MEM/SUPPLY SHALL complete even if cctrans[owner] drops mid-word; RAM strobes are never withdrawn before ramready.
REQ-028 The non-owner cache SHALL see dwait=1 at all times; ccwait/ccinv SHALL be 0 outside SNOOP/SUPPLY.
REQ-029 Outputs SHALL be combinational from state/owner and inputs; unused data outputs SHALL be 0.
REQ-030 Latency, read with no dirty snoop: request in IDLE -> SNOOP -> MEM; earliest dwait low is cycle 3, when ramready is high on entry to MEM.

Reset
REQ-031 RST high at a rising edge: state=IDLE, owner=0, last_grant=1; cache 0 wins the first tie.
REQ-032 While in reset: dwait=2'b11; ccwait, ccinv, ramREN, ramWEN = 0; ramaddr, ramstore, dload, ccsnoopaddr = 0.
REQ-033 RST mid-transaction SHALL abort the transaction with no writeback; RAM strobes are low the cycle after the reset edge.

Verification
REQ-034 Cache0 read 0x100, ccdirty[1]=0, ramload=0xDEADBEEF, ramready=1 -> SNOOP with ccsnoopaddr[1]=0x100; then MEM with dload[0]=0xDEADBEEF, dwait[0]=0.
REQ-035 Cache1 read with ccwrite[1]=1, ccdirty[0]=1, dstore[0]=0x1234 -> ccinv[0]=1; SUPPLY with ramWEN=1, ramstore=0x1234, dload[1]=0x1234.
REQ-036 Both caches request at reset exit -> cache0 served first; on its cctrans drop, cache1 is granted after DONE; next tie goes to cache0.
REQ-037 Cache0 two-word writeback (0x200, 0x204), cctrans held, cache1 requesting throughout -> both words served with no SNOOP, then cache1 granted.
REQ-038 ramready held low 5 cycles in MEM, with cctrans[owner] dropped in cycle 2 -> ramWEN stays high until ramready, then DONE -> IDLE.
REQ-039 RST asserted in SUPPLY -> next cycle IDLE, ccwait=0, ramWEN=0, dwait=2'b11.
